// File: rtl/sysid_check_ctrl.sv
// Avalon-MM read master that fetches the system-ID and build-timestamp words and checks them
// against build-time values. Define SYSID_CHECK_IRQ_EN to add the irq/irq_ack mismatch interrupt.
`timescale 1ns/1ps
module sysid_check_ctrl #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1605368152,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
`ifdef SYSID_CHECK_IRQ_EN
    ,
    output logic        irq,
    input  logic        irq_ack
`endif
);
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ_ID, S_WAIT_ID, S_REQ_TS, S_WAIT_TS, S_DONE, S_FAIL
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_read;
    logic             r_addr;
    logic             r_busy;
    logic             r_done;
    logic             r_id_ok;
    logic             r_ts_ok;
    logic             r_tmo;
    logic [31:0]      r_cap_id;
    logic [31:0]      r_cap_ts;

    logic w_in_req;
    logic w_in_wait;
    logic w_restart;
    logic w_expire;
    logic w_to_fail;
    logic w_to_done;

    assign w_in_req  = (r_state == S_REQ_ID) || (r_state == S_REQ_TS);
    assign w_in_wait = (r_state == S_WAIT_ID) || (r_state == S_WAIT_TS);
    assign w_restart = ((r_state == S_IDLE) && (AUTO_START || start)) ||
                       (((r_state == S_DONE) || (r_state == S_FAIL)) && start);
    // Counter is about to hit zero this cycle; data arriving on that same cycle still wins.
    assign w_expire  = (r_cnt == CNT_LAST);
    assign w_to_fail = w_expire && (w_in_req || (w_in_wait && !avm_readdatavalid));
    assign w_to_done = (r_state == S_WAIT_TS) && avm_readdatavalid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_read   <= 1'b0;
            r_addr   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_id_ok  <= 1'b0;
            r_ts_ok  <= 1'b0;
            r_tmo    <= 1'b0;
            r_cap_id <= '0;
            r_cap_ts <= '0;
        end else if (w_restart) begin
            r_state  <= S_REQ_ID;
            r_cnt    <= CNT_LOAD;
            r_read   <= 1'b1;
            r_addr   <= 1'b0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_id_ok  <= 1'b0;
            r_ts_ok  <= 1'b0;
            r_tmo    <= 1'b0;
            r_cap_id <= '0;
            r_cap_ts <= '0;
        end else if (w_to_fail) begin
            r_state <= S_FAIL;
            r_read  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_tmo   <= 1'b1;
        end else begin
            if (w_in_req || w_in_wait) begin
                r_cnt <= r_cnt - 1'b1;
            end
            case (r_state)
                S_REQ_ID: begin
                    if (!avm_waitrequest) begin
                        r_state <= S_WAIT_ID;
                        r_read  <= 1'b0;
                    end
                end
                S_WAIT_ID: begin
                    if (avm_readdatavalid) begin
                        r_cap_id <= avm_readdata;
                        r_id_ok  <= (avm_readdata == EXPECTED_ID);
                        r_state  <= S_REQ_TS;
                        r_read   <= 1'b1;
                        r_addr   <= 1'b1;
                        r_cnt    <= CNT_LOAD;
                    end
                end
                S_REQ_TS: begin
                    if (!avm_waitrequest) begin
                        r_state <= S_WAIT_TS;
                        r_read  <= 1'b0;
                    end
                end
                S_WAIT_TS: begin
                    if (w_to_done) begin
                        r_cap_ts <= avm_readdata;
                        r_ts_ok  <= (avm_readdata == EXPECTED_TS);
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign avm_address = r_addr;
    assign avm_read    = r_read;
    assign busy        = r_busy;
    assign done        = r_done;
    assign id_ok       = r_id_ok;
    assign ts_ok       = r_ts_ok;
    assign timeout_err = r_tmo;
    assign captured_id = r_cap_id;
    assign captured_ts = r_cap_ts;

`ifdef SYSID_CHECK_IRQ_EN
    logic r_irq;
    logic w_irq_set;

    // A bad timestamp is detected on the same edge that enters DONE, so compare the live data.
    assign w_irq_set = w_to_fail ||
                       (w_to_done && (!r_id_ok || (avm_readdata != EXPECTED_TS)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else if (w_irq_set) begin
            r_irq <= 1'b1;
        end else if (w_restart || irq_ack) begin
            r_irq <= 1'b0;
        end
    end

    assign irq = r_irq;
`endif
endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Scoreboard bench for sysid_check_ctrl: a reference model predicts each check's outcome,
// a slave model answers the reads, and a monitor compares every completed check.
`timescale 1ns/1ps
module tb_sysid_check_ctrl;
    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1605368152;
    localparam int          T      = 12;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'd0;
    logic        avm_readdatavalid = 1'b0;
    logic        busy, done, id_ok, ts_ok, timeout_err;
    logic [31:0] captured_id, captured_ts;
`ifdef SYSID_CHECK_IRQ_EN
    logic        irq;
    logic        irq_ack = 1'b0;
`endif

    sysid_check_ctrl #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .TIMEOUT_CYCLES(T), .AUTO_START(1'b1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .timeout_err(timeout_err),
        .captured_id(captured_id), .captured_ts(captured_ts)
`ifdef SYSID_CHECK_IRQ_EN
        , .irq(irq), .irq_ack(irq_ack)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        logic [31:0] id;
        logic [31:0] ts;
        bit          id_ok;
        bit          ts_ok;
        bit          tmo;
        bit          irq;
        int          lat;
        int          rdcyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Slave behaviour per word: stall cycles, response latency after accept (0 = never), data.
    int          cfg_w [2];
    int          cfg_l [2];
    logic [31:0] cfg_d [2];
    int          stray_seq = 0;
    int          clr_seq   = 0;
    logic [31:0] stray_data = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Word k completes iff its stall + accept cycle + response latency fit in T cycles.
    function automatic exp_t model(input int w0, input int l0, input logic [31:0] d0,
                                   input int w1, input int l1, input logic [31:0] d1);
        exp_t e;
        int   t0, t1;
        e = '{id: 32'd0, ts: 32'd0, id_ok: 1'b0, ts_ok: 1'b0, tmo: 1'b0, irq: 1'b0, lat: 0, rdcyc: 0};
        t0 = w0 + 1 + l0;
        t1 = w1 + 1 + l1;
        if (l0 == 0 || t0 > T) begin
            e.tmo   = 1'b1;
            e.lat   = T;
            e.rdcyc = (w0 + 1 < T) ? w0 + 1 : T;
        end else begin
            e.id    = d0;
            e.id_ok = (d0 == EXP_ID);
            if (l1 == 0 || t1 > T) begin
                e.tmo   = 1'b1;
                e.lat   = t0 + T;
                e.rdcyc = (w0 + 1) + ((w1 + 1 < T) ? w1 + 1 : T);
            end else begin
                e.ts    = d1;
                e.ts_ok = (d1 == EXP_TS);
                e.lat   = t0 + t1;
                e.rdcyc = w0 + w1 + 2;
            end
        end
        e.irq = e.tmo || !e.id_ok || !e.ts_ok;
        return e;
    endfunction

    // ---------------- Avalon slave model ----------------
    int s_stall = 0, s_pend = 0, s_word = 0, stray_seen = 0, clr_seen = 0;
    bit s_acc = 1'b0, s_inreq = 1'b0;
    initial begin
        forever begin
            @(negedge clock);
            avm_readdatavalid = 1'b0;
            if (clr_seq != clr_seen) begin
                clr_seen = clr_seq;
                s_acc = 1'b0; s_pend = 0; s_inreq = 1'b0;
            end
            if (s_acc) begin
                s_acc  = 1'b0;
                s_pend = cfg_l[s_word];
            end
            if (s_pend > 0) begin
                s_pend--;
                if (s_pend == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = cfg_d[s_word];
                end
            end
            if (stray_seq != stray_seen) begin
                stray_seen        = stray_seq;
                avm_readdatavalid = 1'b1;
                avm_readdata      = stray_data;
            end
            if (avm_read && reset_n) begin
                if (!s_inreq) begin
                    s_inreq = 1'b1;
                    s_word  = avm_address ? 1 : 0;
                    s_stall = cfg_w[s_word];
                end
                if (s_stall > 0) begin
                    avm_waitrequest = 1'b1;
                    s_stall--;
                end else begin
                    avm_waitrequest = 1'b0;
                    s_acc   = 1'b1;
                    s_inreq = 1'b0;
                end
            end else begin
                avm_waitrequest = 1'b0;
                s_inreq = 1'b0;
            end
        end
    end

    // ---------------- Monitor ----------------
    int   m_t0 = 0, m_rdcyc = 0, m_rise = 0;
    bit   m_prev_busy = 1'b0, m_prev_done = 1'b0, m_prev_read = 1'b0;
    exp_t m_e;
    initial begin
        forever begin
            @(negedge clock);
            if (busy && !m_prev_busy) begin
                m_t0 = cyc; m_rdcyc = 0; m_rise = 0;
            end
            if (avm_read && !m_prev_read) m_rise++;
            if (avm_read) begin
                m_rdcyc++;
                chk("avm_address", {31'd0, avm_address}, 32'(m_rise - 1));
            end
            if (done && !m_prev_done) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_done: done rose with no check pending, expected none");
                end else begin
                    m_e = exp_q.pop_front();
                    chk("captured_id", captured_id, m_e.id);
                    chk("captured_ts", captured_ts, m_e.ts);
                    chk("id_ok", {31'd0, id_ok}, {31'd0, m_e.id_ok});
                    chk("ts_ok", {31'd0, ts_ok}, {31'd0, m_e.ts_ok});
                    chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_e.tmo});
                    chk("busy_at_done", {31'd0, busy}, 32'd0);
                    chk("latency", 32'(cyc - m_t0), 32'(m_e.lat));
                    chk("read_cycles", 32'(m_rdcyc), 32'(m_e.rdcyc));
`ifdef SYSID_CHECK_IRQ_EN
                    chk("irq", {31'd0, irq}, {31'd0, m_e.irq});
`endif
                end
            end
            m_prev_busy = busy;
            m_prev_done = done;
            m_prev_read = avm_read;
        end
    end

    // ---------------- Stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cfg(input int w0, input int l0, input logic [31:0] d0,
                           input int w1, input int l1, input logic [31:0] d1);
        cfg_w[0] = w0; cfg_l[0] = l0; cfg_d[0] = d0;
        cfg_w[1] = w1; cfg_l[1] = l1; cfg_d[1] = d1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_q(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            tick();
            n++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: check never finished, %0d results pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (16) tick();
    endtask

    task automatic run(input string name, input int w0, input int l0, input logic [31:0] d0,
                       input int w1, input int l1, input logic [31:0] d1, input bit busy_start);
        set_cfg(w0, l0, d0, w1, l1, d1);
        exp_q.push_back(model(w0, l0, d0, w1, l1, d1));
        pulse_start();
        if (busy_start) begin
            tick();
            tick();
            pulse_start();
        end
        wait_q(name);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {25'd0, busy, done, id_ok, ts_ok, timeout_err, avm_read, avm_address}, 32'd0);
        chk({tag, "_captured_id"}, captured_id, 32'd0);
        chk({tag, "_captured_ts"}, captured_ts, 32'd0);
`ifdef SYSID_CHECK_IRQ_EN
        chk({tag, "_irq"}, {31'd0, irq}, 32'd0);
`endif
    endtask

    int          rw0, rw1, rl0, rl1;
    logic [31:0] rd0, rd1;
    bit          rbs;

    initial begin
        // Auto-start after reset release with an ideal slave
        set_cfg(0, 1, EXP_ID, 0, 1, EXP_TS);
        exp_q.push_back(model(0, 1, EXP_ID, 0, 1, EXP_TS));
        #3;
        chk_all_zero("reset");
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        wait_q("auto_start");

        // Timestamp mismatch, then interrupt acknowledge
        run("ts_mismatch", 0, 1, EXP_ID, 0, 1, 32'h12345678, 1'b0);
`ifdef SYSID_CHECK_IRQ_EN
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("irq_after_ack", {31'd0, irq}, 32'd0);
`endif

        // Long waitrequest stall on word 0, exactly filling the timeout window
        run("stall10", 10, 1, EXP_ID, 0, 1, EXP_TS, 1'b0);

        // Word 1 never answered; a late stray response must not be captured
        run("ts_timeout", 0, 1, EXP_ID, 0, 0, EXP_TS, 1'b0);
        stray_data = EXP_TS;
        stray_seq++;
        repeat (3) tick();
        chk("stray_captured_ts", captured_ts, 32'd0);
        chk("stray_ts_ok", {31'd0, ts_ok}, 32'd0);
        chk("stray_done", {31'd0, done}, 32'd1);
        chk("stray_timeout_err", {31'd0, timeout_err}, 32'd1);

        // Timeout boundaries: data on the last cycle wins, one cycle later loses
        run("id_edge_ok", 3, 8, EXP_ID, 0, 1, EXP_TS, 1'b0);
        run("ts_edge_late", 0, 1, EXP_ID, 3, 9, EXP_TS, 1'b0);
        run("id_stall_tmo", 11, 1, EXP_ID, 0, 1, EXP_TS, 1'b0);
        run("ts_edge_ok", 0, 1, EXP_ID, 10, 1, EXP_TS, 1'b0);

        // start while busy is ignored; start in DONE clears flags and reruns identically
        run("busy_start", 1, 2, 32'hDEADBEEF, 0, 3, EXP_TS, 1'b1);
        exp_q.push_back(model(1, 2, 32'hDEADBEEF, 0, 3, EXP_TS));
        pulse_start();
        chk("rerun_busy", {31'd0, busy}, 32'd1);
        chk("rerun_done", {31'd0, done}, 32'd0);
        chk("rerun_captured_id", captured_id, 32'd0);
        chk("rerun_captured_ts", captured_ts, 32'd0);
        chk("rerun_ts_ok", {31'd0, ts_ok}, 32'd0);
        wait_q("rerun");

        // Reset while waiting for word 0, then a stray response right after release
        set_cfg(0, 6, EXP_ID, 0, 1, EXP_TS);
        pulse_start();
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        clr_seq++;
        #1;
        chk_all_zero("midreset");
        set_cfg(0, 1, EXP_ID, 0, 1, EXP_TS);
        exp_q.push_back(model(0, 1, EXP_ID, 0, 1, EXP_TS));
        tick();
        reset_n = 1'b1;
        stray_data = 32'hA5A5A5A5;
        stray_seq++;
        tick();
        chk("post_reset_captured_id", captured_id, 32'd0);
        chk("post_reset_busy", {31'd0, busy}, 32'd1);
        wait_q("post_reset");

        // Randomised checks
        for (int i = 0; i < 25; i++) begin
            rw0 = $urandom_range(0, 5);
            rw1 = $urandom_range(0, 5);
            rl0 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, T - rw0);
            rl1 = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, T - rw1);
            rd0 = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
            rd1 = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
            rbs = ($urandom_range(0, 3) == 0);
            run("random", rw0, rl0, rd0, rw1, rl1, rd1, rbs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
